// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: states, ISA constants and opcode dispatch for cpu_controller (memory ops under CPU_CTRL_MEM_EN)
package cpu_ctrl_pkg;
  typedef enum logic [3:0] {
    S_WAIT, S_DECODE, S_GET_A, S_GET_B, S_ALU, S_CMP, S_WR_REG, S_WR_IMM,
    S_HALT, S_ADDR, S_LD_ADDR, S_MEM_RD, S_WR_MEM, S_GET_D, S_PASS, S_ST_MEM
  } state_t;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;
  localparam logic [2:0] OPC_LDR = 3'b011;
  localparam logic [2:0] OPC_STR = 3'b100;
  localparam logic [2:0] OPC_HLT = 3'b111;

  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;
  localparam logic [1:0] OP_MEM     = 2'b00;

  localparam logic [1:0] NSEL_RN = 2'b00;
  localparam logic [1:0] NSEL_RD = 2'b01;
  localparam logic [1:0] NSEL_RM = 2'b10;

  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_IMM   = 2'b01;
  localparam logic [1:0] VSEL_MDATA = 2'b10;
  localparam logic [1:0] VSEL_ZERO  = 2'b11;

  localparam logic [1:0] MEM_NONE = 2'b00;
  localparam logic [1:0] MEM_RD   = 2'b01;
  localparam logic [1:0] MEM_WR   = 2'b10;

  // First execution state after DECODE; S_WAIT marks an undefined instruction.
  function automatic state_t decode_next(input logic [2:0] opc, input logic [1:0] op);
    if (opc == OPC_HLT) return S_HALT;
    case ({opc, op})
      {OPC_MOV, OP_MOV_IMM}: return S_WR_IMM;
      {OPC_MOV, OP_MOV_REG}: return S_GET_B;
      {OPC_ALU, OP_MVN}:     return S_GET_B;
      {OPC_ALU, OP_ADD}:     return S_GET_A;
      {OPC_ALU, OP_CMP}:     return S_GET_A;
      {OPC_ALU, OP_AND}:     return S_GET_A;
`ifdef CPU_CTRL_MEM_EN
      {OPC_LDR, OP_MEM}:     return S_GET_A;
      {OPC_STR, OP_MEM}:     return S_GET_A;
`endif
      default:               return S_WAIT;
    endcase
  endfunction
endpackage

// File: rtl/cpu_controller_instr_reg.sv
// instr_reg: load-enabled instruction register with asynchronous active-low clear
module instr_reg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  // Capture on enable, clear immediately on reset.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/cpu_controller.sv
// cpu_controller: IR plus Moore sequencing FSM for the 16-bit RISC datapath (LDR/STR under CPU_CTRL_MEM_EN)
module cpu_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int IR_W = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [IR_W-1:0] in,
  input  logic            load,
  input  logic            s,
  input  logic [2:0]      opcode,
  input  logic [1:0]      op,
  output logic [IR_W-1:0] ir,
  output logic [1:0]      nsel,
  output logic [1:0]      vsel,
  output logic            write,
  output logic            loada,
  output logic            loadb,
  output logic            loadc,
  output logic            loads,
  output logic            asel,
  output logic            bsel,
  output logic [1:0]      mem_cmd,
  output logic            load_addr,
  output logic            w,
  output logic            halted,
  output logic            illegal
);
  state_t state, next;

  instr_reg #(.W(IR_W)) u_ir (
    .clk(clk),
    .reset_n(reset_n),
    .en(load && state == S_WAIT),
    .d(in),
    .q(ir)
  );

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= S_WAIT;
    else state <= next;

  // Sequencing; terminal states and unused encodings fall back to WAIT.
  always_comb begin
    next = S_WAIT;
    case (state)
      S_WAIT:    next = s ? S_DECODE : S_WAIT;
      S_DECODE:  next = decode_next(opcode, op);
`ifdef CPU_CTRL_MEM_EN
      S_GET_A:   next = (opcode == OPC_LDR || opcode == OPC_STR) ? S_ADDR : S_GET_B;
      S_ADDR:    next = S_LD_ADDR;
      S_LD_ADDR: next = opcode == OPC_LDR ? S_MEM_RD : S_GET_D;
      S_MEM_RD:  next = S_WR_MEM;
      S_GET_D:   next = S_PASS;
      S_PASS:    next = S_ST_MEM;
`else
      S_GET_A:   next = S_GET_B;
`endif
      S_GET_B:   next = {opcode, op} == {OPC_ALU, OP_CMP} ? S_CMP : S_ALU;
      S_ALU:     next = S_WR_REG;
      S_HALT:    next = S_HALT;
      default:   next = S_WAIT;
    endcase
  end

  // Moore outputs from state and IR only; A is zeroed for the single-operand moves.
  always_comb begin
    nsel = NSEL_RN;
    vsel = VSEL_C;
    write = 1'b0;
    loada = 1'b0;
    loadb = 1'b0;
    loadc = 1'b0;
    loads = 1'b0;
    asel = 1'b0;
    bsel = 1'b0;
    mem_cmd = MEM_NONE;
    load_addr = 1'b0;
    halted = 1'b0;
    illegal = 1'b0;
    w = state == S_WAIT;
    case (state)
      S_DECODE:  illegal = decode_next(ir[15:13], ir[12:11]) == S_WAIT;
      S_GET_A:   loada = 1'b1;
      S_GET_B: begin
        nsel = NSEL_RM;
        loadb = 1'b1;
      end
      S_ALU: begin
        loadc = 1'b1;
        asel = ir[15:11] == {OPC_MOV, OP_MOV_REG} || ir[15:11] == {OPC_ALU, OP_MVN};
      end
      S_CMP:     loads = 1'b1;
      S_WR_REG: begin
        nsel = NSEL_RD;
        write = 1'b1;
      end
      S_WR_IMM: begin
        vsel = VSEL_IMM;
        write = 1'b1;
      end
      S_HALT:    halted = 1'b1;
`ifdef CPU_CTRL_MEM_EN
      S_ADDR: begin
        bsel = 1'b1;
        loadc = 1'b1;
      end
      S_LD_ADDR: load_addr = 1'b1;
      S_MEM_RD:  mem_cmd = MEM_RD;
      S_WR_MEM: begin
        nsel = NSEL_RD;
        vsel = VSEL_MDATA;
        mem_cmd = MEM_RD;
        write = 1'b1;
      end
      S_GET_D: begin
        nsel = NSEL_RD;
        loadb = 1'b1;
      end
      S_PASS: begin
        asel = 1'b1;
        loadc = 1'b1;
      end
      S_ST_MEM:  mem_cmd = MEM_WR;
`endif
      default: ;
    endcase
  end
endmodule

// File: doc/cpu_controller.md
Name: cpu_controller

Overview:
Sequencing stage for the 16-bit RISC datapath: holds the instruction register, feeds it to the instruction decoder, and runs a Moore FSM on the decoded opcode/op. The FSM drives register-file select (nsel), datapath load/select strobes and write-back.
Sits between the instruction source (in/load/s) and the decoder plus datapath. One instruction runs at a time; w signals readiness.

Parameters:
IR_W, 16, instruction width (fixed ISA; kept for lint/test only)

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous, active-low reset
in  in  16  instruction to capture
load  in  1  capture in into IR (honoured only in WAIT)
s  in  1  start execution of IR (sampled only in WAIT)
opcode  in  3  from decoder (IR[15:13])
op  in  2  from decoder (IR[12:11])
ir  out  16  instruction register contents to decoder
nsel  out  2  00 Rn, 01 Rd, 10 Rm
vsel  out  2  00 datapath C, 01 sximm8, 10 mdata, 11 zero
write  out  1  register-file write enable
loada, loadb, loadc, loads  out  1 each  datapath register strobes
asel  out  1  1 = force A operand to zero
bsel  out  1  1 = B operand is sximm5
mem_cmd  out  2  00 none, 01 read, 10 write (MEM_EN only; else 00)
load_addr  out  1  capture C into address register (MEM_EN only; else 0)
w  out  1  idle/ready
halted  out  1  HALT reached
illegal  out  1  undefined instruction decoded, one-cycle pulse

Behaviour:
- Reset (async, reset_n=0): state=WAIT, ir=16'h0000. All strobes, nsel, vsel and mem_cmd are 0; w=1.
- IR: ir<=in on the clk edge when load=1 and state==WAIT. load is ignored in every other state, so IR stays stable during execution.
- All control outputs are decoded combinationally from the state register plus ir (Moore style); there are no input-to-output paths.
- Asserting load and s in the same WAIT cycle captures the new IR and executes that new instruction.
- WAIT: w=1, all else 0. If s=1, go to DECODE; otherwise stay.
- DECODE: all strobes 0. Next state by {opcode,op}:
  - 110_10 MOV imm -> WR_IMM
  - 110_00 MOV reg -> GET_B
  - 101_11 MVN -> GET_B
  - 101_00 ADD, 101_01 CMP, 101_10 AND -> GET_A
  - 111_xx HALT -> HALT
  - anything else: illegal=1 this cycle, next state WAIT.
- GET_A: nsel=00, loada=1 -> GET_B.
- GET_B: nsel=10, loadb=1. Next is CMP if opcode/op=101_01, else ALU.
- ALU: loadc=1, bsel=0, asel=1 for MOV reg and MVN (asel=0 otherwise) -> WR_REG.
- CMP: loads=1, loadc=0 -> WAIT.
- WR_REG: nsel=01, vsel=00, write=1 -> WAIT.
- WR_IMM: nsel=00, vsel=01, write=1 -> WAIT.
- HALT: halted=1, w=0. Stays in HALT until reset_n=0; s and load are ignored.
- Cycles with w=0, counted from the edge that samples s=1:
  - MOV imm: 2
  - MOV reg and MVN: 4
  - CMP: 4
  - ADD and AND: 5
  - illegal: 1
- Reset asserted mid-instruction aborts it immediately. No write occurs after reset assertion, and ir clears.
- Undefined state encodings recover to WAIT.

Optional Feature:
CPU_CTRL_MEM_EN.
- Defined: LDR (011_00, Rd=M[Rn+sximm5]) and STR (100_00, M[Rn+sximm5]=Rd) are legal.
  - Shared prefix: DECODE -> GET_A -> ADDR (asel=0, bsel=1, loadc=1) -> LD_ADDR (load_addr=1).
  - LDR continues: -> MEM_RD (mem_cmd=01) -> WR_MEM (nsel=01, vsel=10, mem_cmd=01, write=1) -> WAIT.
  - STR continues: -> GET_D (nsel=01, loadb=1) -> PASS (asel=1, loadc=1) -> ST_MEM (mem_cmd=10) -> WAIT.
  - LDR holds w=0 for 6 cycles; STR holds w=0 for 7 cycles.
- Undefined: 011/100 are illegal; mem_cmd and load_addr are tied to 0.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - state enum
  - opcode constants (OPC_MOV=3'b110, OPC_ALU=3'b101, OPC_LDR=3'b011, OPC_STR=3'b100, OPC_HLT=3'b111)
  - NSEL_RN/RD/RM, VSEL_C/IMM/MDATA/ZERO, MEM_NONE/RD/WR
- One sub-module, instr_reg: 16-bit load-enabled register with async active-low clear.

Test Plan:
- Reset, then load 16'hD007 and pulse s (MOV R0,#7) -> DECODE then WR_IMM with nsel=00, vsel=01, write=1; w low for exactly 2 cycles.
- Load 16'hA140 (ADD R2,R1,R0) and pulse s -> GET_A (loada, nsel=00), GET_B (loadb, nsel=10), ALU (loadc, asel=0), WR_REG (nsel=01, write); w low 5 cycles.
- 16'hA900 (CMP) -> loads=1 in the fourth cycle, write never asserted. 16'hB861 (MVN R3,R1) -> asel=1 in ALU, 4 cycles.
- 16'h0000 and s -> illegal pulses 1 cycle in DECODE, back to WAIT, no strobes. A load pulse during ADD execution leaves ir unchanged.
- 16'hE000 (HALT) -> halted=1, w=0 held for 20 cycles despite s/load. reset_n low mid-ADD (GET_B) -> immediately WAIT, ir=0, write=0.
- CPU_CTRL_MEM_EN: 16'h6045 (LDR R2,[R0,#5]) -> bsel=1 in ADDR, load_addr, mem_cmd=01 for two cycles, vsel=10 write; w low 6 cycles.
